// File: rtl/aes_sbox_arb.sv
// aes_sbox_arb: shares one 32-bit S-box between key expansion (1 word) and the round datapath (4 words)
module aes_sbox_arb #(
    parameter int ARB_MODE = 0
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_key_req,
    input  logic [31:0]  i_key_wrd,
    output logic         o_key_gnt,
    output logic         o_key_vld,
    output logic [31:0]  o_key_wrd,
    input  logic         i_rnd_req,
    input  logic [127:0] i_rnd_blk,
    output logic         o_rnd_gnt,
    output logic         o_rnd_vld,
    output logic [127:0] o_rnd_blk,
    output logic [31:0]  o_sbox_wrd,
    input  logic [31:0]  i_sbox_wrd,
    output logic         o_busy
);
    typedef enum logic [1:0] {IDLE, KEY, RND} state_t;
    state_t        state, state_nx;
    logic          ptr_key;
    logic          key_win;
    logic [1:0]    cnt;
    logic [127:0]  blk_q;
    logic [95:0]   shadow;
    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nx;
    end
    // Arbitration, grants, S-box word select and next state; word cnt selects bits [127-32*cnt -: 32]
    always_comb begin
        key_win    = i_key_req && (!i_rnd_req || ARB_MODE != 0 || ptr_key);
        o_key_gnt  = state == IDLE && key_win;
        o_rnd_gnt  = state == IDLE && i_rnd_req && !key_win;
        o_busy     = state != IDLE;
        o_sbox_wrd = state == KEY ? blk_q[31:0] : state == RND ? blk_q[{~cnt, 5'd0} +: 32] : '0;
        state_nx   = o_key_gnt ? KEY : o_rnd_gnt ? RND : (state == RND && cnt != 2'd3) ? RND : IDLE;
    end
    // Capture granted input, collect substituted words, publish results with a one-cycle valid
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ptr_key   <= 1'b1;
            cnt       <= '0;
            blk_q     <= '0;
            shadow    <= '0;
            o_key_wrd <= '0;
            o_rnd_blk <= '0;
            o_key_vld <= 1'b0;
            o_rnd_vld <= 1'b0;
        end else begin
            o_key_vld <= state == KEY;
            o_rnd_vld <= state == RND && cnt == 2'd3;
            if (o_key_gnt || o_rnd_gnt) ptr_key <= o_rnd_gnt;
            if (o_key_gnt) blk_q <= {96'd0, i_key_wrd};
            if (o_rnd_gnt) blk_q <= i_rnd_blk;
            if (state == KEY) o_key_wrd <= i_sbox_wrd;
            if (state == RND) begin
                cnt    <= cnt + 2'd1;
                shadow <= {shadow[63:0], i_sbox_wrd};
                if (cnt == 2'd3) o_rnd_blk <= {shadow, i_sbox_wrd};
            end
        end
    end
endmodule

// File: tb/tb_aes_sbox_arb.sv
// tb_aes_sbox_arb: directed vector bench for the shared S-box arbiter in both arbitration modes
module tb_aes_sbox_arb;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         kreq0, kgnt0, kvld0, rreq0, rgnt0, rvld0, busy0;
    logic [31:0]  kw0, kout0, sbo0, sbi0;
    logic [127:0] rb0, rout0;
    logic         kreq1, kgnt1, kvld1, rreq1, rgnt1, rvld1, busy1;
    logic [31:0]  kw1, kout1, sbo1, sbi1;
    logic [127:0] rb1, rout1;

    aes_sbox_arb #(.ARB_MODE(0)) dut0 (
        .i_clk(clk), .i_rst(rst),
        .i_key_req(kreq0), .i_key_wrd(kw0), .o_key_gnt(kgnt0), .o_key_vld(kvld0), .o_key_wrd(kout0),
        .i_rnd_req(rreq0), .i_rnd_blk(rb0), .o_rnd_gnt(rgnt0), .o_rnd_vld(rvld0), .o_rnd_blk(rout0),
        .o_sbox_wrd(sbo0), .i_sbox_wrd(sbi0), .o_busy(busy0)
    );
    aes_sbox_arb #(.ARB_MODE(1)) dut1 (
        .i_clk(clk), .i_rst(rst),
        .i_key_req(kreq1), .i_key_wrd(kw1), .o_key_gnt(kgnt1), .o_key_vld(kvld1), .o_key_wrd(kout1),
        .i_rnd_req(rreq1), .i_rnd_blk(rb1), .o_rnd_gnt(rgnt1), .o_rnd_vld(rvld1), .o_rnd_blk(rout1),
        .o_sbox_wrd(sbo1), .i_sbox_wrd(sbi1), .o_busy(busy1)
    );

    // AES forward S-box, entry 0 in the leftmost byte
    logic [0:2047] sbt;
    initial sbt = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    // Combinational S-box models feeding each instance
    always_comb begin
        sbi0 = '0;
        for (int b = 0; b < 4; b++) sbi0[8*b +: 8] = sbt[8*sbo0[8*b +: 8] +: 8];
    end
    always_comb begin
        sbi1 = '0;
        for (int b = 0; b < 4; b++) sbi1[8*b +: 8] = sbt[8*sbo1[8*b +: 8] +: 8];
    end

    int total = 0;
    int passed = 0;

    typedef struct {
        logic         rnd;
        logic [127:0] din;
        logic [127:0] exp;
    } vec_t;
    vec_t vt[7];

    localparam logic [127:0] RIN  = 128'h00112233_44556677_8899aabb_ccddeeff;
    localparam logic [127:0] ROUT = 128'h638293c3_1bfc33f5_c4eeacea_4bc12816;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else passed++;
    endtask

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    // One isolated transaction on instance 0; inputs are scrambled right after the grant
    task automatic run_one(input vec_t v);
        int lat;
        if (v.rnd) begin rreq0 = 1'b1; rb0 = v.din; end
        else begin kreq0 = 1'b1; kw0 = v.din[31:0]; end
        #1;
        chk("grant", {kgnt0, rgnt0}, v.rnd ? 2'b01 : 2'b10);
        lat = 0;
        do begin
            nxt;
            lat++;
            kreq0 = 1'b0; rreq0 = 1'b0; kw0 = '1; rb0 = '1;
            #1;
        end while (!(v.rnd ? rvld0 : kvld0) && lat < 8);
        chk("latency", lat, v.rnd ? 5 : 2);
        chk("result", v.rnd ? rout0 : {96'd0, kout0}, v.exp);
        nxt;
        #1;
        chk("vld_pulse", {kvld0, rvld0}, 2'b00);
        chk("hold", v.rnd ? rout0 : {96'd0, kout0}, v.exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vt[0] = '{1'b0, 128'h00010203, 128'h637c777b};
        vt[1] = '{1'b0, 128'hffffffff, 128'h16161616};
        vt[2] = '{1'b1, RIN, ROUT};
        vt[3] = '{1'b0, 128'h53535353, 128'hedededed};
        vt[4] = '{1'b1, 128'h0, 128'h63636363_63636363_63636363_63636363};
        vt[5] = '{1'b0, 128'h01234567, 128'h7c266e85};
        vt[6] = '{1'b1, 128'h01234567_89abcdef_fedcba98_76543210, 128'h7c266e85_a762bddf_bb86f446_382023ca};
        kreq0 = 0; rreq0 = 0; kw0 = '0; rb0 = '0;
        kreq1 = 0; rreq1 = 0; kw1 = '0; rb1 = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rst_ctrl0", {kgnt0, rgnt0, kvld0, rvld0, busy0}, 5'b0);
        chk("rst_data0", {kout0, sbo0}, 64'b0);
        chk("rst_blk0", rout0, 128'b0);
        chk("rst_ctrl1", {kgnt1, rgnt1, kvld1, rvld1, busy1, kout1, sbo1}, 69'b0);
        chk("rst_blk1", rout1, 128'b0);

        for (int i = 0; i < 7; i++) run_one(vt[i]);
        chk("key_hold_across_rnd", kout0, 128'h7c266e85);

        rreq0 = 1'b1; rb0 = RIN;
        #1;
        chk("rnd_grant", {kgnt0, rgnt0}, 2'b01);
        for (int k = 0; k < 4; k++) begin
            nxt;
            rreq0 = 1'b0; rb0 = '0;
            #1;
            chk("sbox_seq", sbo0, RIN[127 - 32*k -: 32]);
            chk("busy", {busy0, rvld0}, 2'b10);
        end
        nxt;
        #1;
        chk("busy_end", {busy0, rvld0}, 2'b01);
        chk("rnd_result", rout0, ROUT);

        rst = 1'b1;
        nxt;
        nxt;
        rst = 1'b0;
        kreq0 = 1'b1; rreq0 = 1'b1; kw0 = 32'h00010203; rb0 = RIN;
        for (int c = 0; c < 15; c++) begin
            #1;
            chk("rr_cycle", {kgnt0, rgnt0, kvld0, rvld0},
                {c == 0 || c == 7 || c == 14, c == 2 || c == 9, c == 2 || c == 9, c == 7 || c == 14});
            nxt;
        end
        kreq0 = 1'b0; rreq0 = 1'b0;
        repeat (3) nxt;
        chk("rr_key_result", kout0, 128'h637c777b);
        chk("rr_rnd_result", rout0, ROUT);

        kreq1 = 1'b1; rreq1 = 1'b1; kw1 = 32'h01234567; rb1 = RIN;
        for (int c = 0; c < 7; c++) begin
            if (c == 5) kreq1 = 1'b0;
            #1;
            chk("prio_cycle", {kgnt1, rgnt1}, {c == 0 || c == 2 || c == 4, c == 6});
            nxt;
        end
        rreq1 = 1'b0;
        repeat (4) nxt;
        chk("prio_rnd_done", {rvld1, kout1}, {1'b1, 32'h7c266e85});
        chk("prio_rnd_result", rout1, ROUT);

        rreq0 = 1'b1; rb0 = vt[6].din;
        #1;
        chk("abort_grant", {kgnt0, rgnt0}, 2'b01);
        nxt;
        rreq0 = 1'b0;
        nxt;
        nxt;
        #1;
        chk("abort_at_cnt2", sbo0, vt[6].din[63:32]);
        rst = 1'b1;
        #1;
        chk("abort_ctrl", {busy0, rvld0, kvld0, sbo0}, 35'b0);
        chk("abort_blk", rout0, 128'b0);
        chk("abort_key", kout0, 128'b0);
        nxt;
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            #1;
            chk("abort_no_vld", {kvld0, rvld0, busy0}, 3'b0);
            nxt;
        end
        run_one(vt[2]);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/aes_sbox_arb.md
Name: aes_sbox_arb

Overview:
Sequencer and arbiter that shares one 32-bit aes_sbox instance between the key-expansion engine and the round datapath.
- Key-expansion requests need one word substituted.
- Round requests need a full 128-bit state substituted. The block streams it through the S-box one word per cycle.
- Each requester gets a registered result and a one-cycle valid pulse.
- The block sits between the AES core controller and its single S-box, so both units use one S-box instead of five.

Parameters:
ARB_MODE, 0, arbitration policy: 0 = round-robin between key and round requesters; 1 = fixed priority, key requester always wins.

Ports:
i_clk  input  1  clock, rising edge
i_rst  input  1  reset, asynchronous, active-high
i_key_req  input  1  key-expansion request; held high until o_key_gnt
i_key_wrd  input  32  key word to substitute; sampled in the o_key_gnt cycle
o_key_gnt  output  1  grant pulse for the key request (combinational)
o_key_vld  output  1  one-cycle pulse: o_key_wrd holds the new result
o_key_wrd  output  32  substituted key word (registered)
i_rnd_req  input  1  round request; held high until o_rnd_gnt
i_rnd_blk  input  128  state to substitute; sampled in the o_rnd_gnt cycle
o_rnd_gnt  output  1  grant pulse for the round request (combinational)
o_rnd_vld  output  1  one-cycle pulse: o_rnd_blk holds the new result
o_rnd_blk  output  128  substituted state (registered)
o_sbox_wrd  output  32  word driven to the S-box input
i_sbox_wrd  input  32  combinational result from the S-box output
o_busy  output  1  high while in state KEY or RND

Behaviour:
- Reset values: state IDLE, round-robin pointer set so the key requester wins next, word counter 0. All outputs are 0: gnt, vld, o_key_wrd, o_rnd_blk, o_sbox_wrd, o_busy.
- Reset is honoured mid-operation. The transaction in flight is aborted with no vld pulse, and result registers return to 0.

FSM states: IDLE, KEY, RND.

IDLE:
- o_sbox_wrd = 0.
- If any request is high, exactly one gnt is asserted in this cycle.
- The granted input is captured into an internal buffer at the clock edge.
- Next state is KEY or RND.

Arbitration:
- Only one request high: that request is granted.
- Both requests high, ARB_MODE=0: the requester not granted last is granted, and the pointer then flips to the other requester.
- Both requests high, ARB_MODE=1: the key requester is always granted.
- A request dropped before its grant has no effect.
- Requests raised while o_busy=1 wait; no grant is issued outside IDLE.

KEY state (1 cycle):
- o_sbox_wrd = buffered word.
- i_sbox_wrd is registered into o_key_wrd.
- Next state is IDLE.
- o_key_vld = 1 in the following cycle.
- Latency: gnt in cycle T, o_key_vld in T+2.

RND state (4 cycles, word counter 0..3):
- Counter 0 drives bits [127:96], 1 drives [95:64], 2 drives [63:32], 3 drives [31:0].
- Each cycle, i_sbox_wrd is written into the matching 32-bit slice of a shadow register.
- o_rnd_blk is updated atomically from the shadow register after counter 3, so there is never a partial update.
- Counter wraps 3→0, and the next state is IDLE.
- o_rnd_vld = 1 in the following cycle.
- Latency: gnt in cycle T, o_rnd_vld in T+5.

Back-to-back operation:
- IDLE is re-entered in the same cycle as the vld pulse, so a new grant may coincide with vld.
- Sustained throughput: one key word per 2 cycles; one round block per 5 cycles.

Outputs between transactions:
- vld pulses last exactly one cycle.
- o_key_wrd and o_rnd_blk hold their values until the next vld for the same requester.
- Input changes after the grant cycle do not affect the result.

Test Plan:
- Key only, after reset: i_key_wrd=0x00010203 with i_key_req=1 → o_key_gnt in the first cycle, o_key_vld 2 cycles later, o_key_wrd=0x637c777b.
- Round only: i_rnd_blk=0x00112233_44556677_8899aabb_ccddeeff → o_rnd_vld 5 cycles after o_rnd_gnt, o_rnd_blk=0x638293c3_1bfc33f5_c4eeacea_4bc12816. Check o_sbox_wrd sequence 0x00112233, 0x44556677, 0x8899aabb, 0xccddeeff. Check o_busy high for exactly 4 cycles.
- Contention, ARB_MODE=0, both requests held high continuously → grants alternate key, rnd, key, rnd. Key granted first after reset. Each grant is issued in the cycle its predecessor's vld fires.
- Contention, ARB_MODE=1, both requests held high for 3 key transactions → three key grants before any round grant. The round grant is issued only once i_key_req drops.
- Reset mid-RND: assert i_rst during counter=2 → no o_rnd_vld pulse, o_rnd_blk=0, state IDLE. The next round request completes with correct data.
- Input stability: change i_key_wrd from 0x00010203 to 0xffffffff one cycle after the grant → o_key_wrd=0x637c777b. o_key_wrd holds that value until the next o_key_vld.
